// File: rtl/mc_core.sv
// mc_core: small multi-cycle 16-bit-instruction core with a FETCH/EXEC/MEM/HALT FSM
// and independent instruction/data request-acknowledge ports.
module mc_core #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int NREG   = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              halted,
  output logic [PC_W-1:0]   dbg_pc
);

  localparam int IDX_W = (NREG > 2) ? $clog2(NREG) : 1;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_LD  = 4'h9;
  localparam logic [3:0] OP_ST  = 4'hA;
  localparam logic [3:0] OP_JMP = 4'hB;
  localparam logic [3:0] OP_JZ  = 4'hC;
  localparam logic [3:0] OP_JNZ = 4'hD;
  localparam logic [3:0] OP_JAL = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   w_pcNext;
  logic [PC_W-1:0]   w_pcPlus1;
  logic              r_z;
  logic              w_zNext;
  logic [15:0]       r_ir;
  logic [DATA_W-1:0] r_regs [NREG];

  logic [3:0]        w_op;
  logic [IDX_W-1:0]  w_rd;
  logic [IDX_W-1:0]  w_rs0;
  logic [IDX_W-1:0]  w_rs1;
  logic [7:0]        w_imm;
  logic [DATA_W-1:0] w_rs0Val;
  logic [DATA_W-1:0] w_rs1Val;
  logic [DATA_W-1:0] w_aluRes;
  logic              w_rdWe;
  logic [DATA_W-1:0] w_rdData;

  // Only the low index bits of each register field select a register.
  assign w_op      = r_ir[15:12];
  assign w_rd      = r_ir[8 +: IDX_W];
  assign w_rs0     = r_ir[4 +: IDX_W];
  assign w_rs1     = r_ir[0 +: IDX_W];
  assign w_imm     = r_ir[7:0];
  assign w_rs0Val  = r_regs[w_rs0];
  assign w_rs1Val  = r_regs[w_rs1];
  assign w_pcPlus1 = r_pc + PC_W'(1);

  always_comb begin
    w_aluRes = '0;
    case (w_op)
      OP_ADD:  w_aluRes = w_rs0Val + w_rs1Val;
      OP_SUB:  w_aluRes = w_rs0Val - w_rs1Val;
      OP_AND:  w_aluRes = w_rs0Val & w_rs1Val;
      OP_OR:   w_aluRes = w_rs0Val | w_rs1Val;
      OP_XOR:  w_aluRes = w_rs0Val ^ w_rs1Val;
      OP_SHL:  w_aluRes = {w_rs0Val[DATA_W-2:0], 1'b0};
      OP_SHR:  w_aluRes = {1'b0, w_rs0Val[DATA_W-1:1]};
      default: w_aluRes = '0;
    endcase
  end

  always_comb begin
    w_nextState = r_state;
    w_pcNext    = r_pc;
    w_zNext     = r_z;
    w_rdWe      = 1'b0;
    w_rdData    = w_aluRes;
    case (r_state)
      S_FETCH: begin
        if (imem_ack) begin
          w_nextState = S_EXEC;
        end
      end
      S_EXEC: begin
        w_nextState = S_FETCH;
        w_pcNext    = w_pcPlus1;
        case (w_op)
          OP_NOP: begin
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
            w_rdWe  = 1'b1;
            w_zNext = (w_aluRes == '0);
          end
          OP_LDI: begin
            w_rdWe   = 1'b1;
            w_rdData = DATA_W'(w_imm);
          end
          OP_LD, OP_ST: begin
            w_nextState = S_MEM;
            w_pcNext    = r_pc;
          end
          OP_JMP: w_pcNext = PC_W'(w_imm);
          OP_JZ:  w_pcNext = r_z ? PC_W'(w_imm) : w_pcPlus1;
          OP_JNZ: w_pcNext = r_z ? w_pcPlus1 : PC_W'(w_imm);
          // Target comes from the pre-write rs0 value, so rd==rs0 links safely.
          OP_JAL: begin
            w_rdWe   = 1'b1;
            w_rdData = DATA_W'(w_pcPlus1);
            w_pcNext = w_rs0Val[PC_W-1:0];
          end
          OP_HLT: begin
            w_nextState = S_HALT;
            w_pcNext    = r_pc;
          end
          default: begin
          end
        endcase
      end
      S_MEM: begin
        if (dmem_ack) begin
          w_nextState = S_FETCH;
          w_pcNext    = w_pcPlus1;
          if (w_op == OP_LD) begin
            w_rdWe   = 1'b1;
            w_rdData = dmem_rdata;
          end
        end
      end
      S_HALT: begin
        w_nextState = S_HALT;
      end
      default: w_nextState = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_z     <= 1'b0;
      r_ir    <= '0;
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_state <= w_nextState;
      r_pc    <= w_pcNext;
      r_z     <= w_zNext;
      if (r_state == S_FETCH && imem_ack) begin
        r_ir <= imem_data;
      end
      if (w_rdWe) begin
        r_regs[w_rd] <= w_rdData;
      end
    end
  end

  // Requests are decoded purely from state, so the two ports can never overlap.
  assign imem_req   = (r_state == S_FETCH);
  assign imem_addr  = r_pc;
  assign dmem_req   = (r_state == S_MEM);
  assign dmem_we    = (r_state == S_MEM) && (w_op == OP_ST);
  assign dmem_addr  = w_rs0Val;
  assign dmem_wdata = w_rs1Val;
  assign halted     = (r_state == S_HALT);
  assign dbg_pc     = r_pc;

endmodule

// File: tb/tb_mc_core.sv
// tb_mc_core: directed self-checking bench for mc_core, with a default 8-bit core
// behind programmable-latency memories and a 16-bit, 4-register core for field and reset checks.
module tb_mc_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [7:0]  dmem_addr;
  logic [7:0]  dmem_wdata;
  logic        dmem_ack;
  logic [7:0]  dmem_rdata;
  logic        halted;
  logic [7:0]  dbg_pc;

  logic        rst2 = 1'b1;
  logic        imem_req2;
  logic [7:0]  imem_addr2;
  logic        imem_ack2;
  logic [15:0] imem_data2;
  logic        dmem_req2;
  logic        dmem_we2;
  logic [15:0] dmem_addr2;
  logic [15:0] dmem_wdata2;
  logic        dmem_ack2;
  logic [15:0] dmem_rdata2;
  logic        halted2;
  logic [7:0]  dbg_pc2;

  int assertions = 0;
  int failures   = 0;

  logic [15:0] imem  [256];
  logic [15:0] imem2 [256];
  int imemDelay = 0;
  int dmemDelay = 0;
  int imemWait  = 0;
  int dmemWait  = 0;
  int dmemWrites = 0;
  int overlaps   = 0;
  logic [7:0] wrAddrLog [64];
  logic [7:0] wrDataLog [64];
  logic ack2En = 1'b1;

  mc_core #(.DATA_W(8), .PC_W(8), .NREG(16)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .halted(halted), .dbg_pc(dbg_pc)
  );

  mc_core #(.DATA_W(16), .PC_W(8), .NREG(4)) u_dut2 (
    .clk(clk), .rst(rst2),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2), .imem_data(imem_data2),
    .dmem_req(dmem_req2), .dmem_we(dmem_we2), .dmem_addr(dmem_addr2), .dmem_wdata(dmem_wdata2),
    .dmem_ack(dmem_ack2), .dmem_rdata(dmem_rdata2), .halted(halted2), .dbg_pc(dbg_pc2)
  );

  // Memory model: ack after a programmable number of wait cycles; loads return addr^A5.
  assign imem_ack    = imem_req && (imemWait >= imemDelay);
  assign imem_data   = imem[imem_addr];
  assign dmem_ack    = dmem_req && (dmemWait >= dmemDelay);
  assign dmem_rdata  = dmem_addr ^ 8'hA5;
  assign imem_ack2   = imem_req2;
  assign imem_data2  = imem2[imem_addr2];
  assign dmem_ack2   = dmem_req2 && ack2En;
  assign dmem_rdata2 = 16'h1234;

  // Wait counters, store log and port-overlap monitor.
  always @(posedge clk) begin
    if (imem_req && !imem_ack) imemWait <= imemWait + 1;
    else                       imemWait <= 0;
    if (dmem_req && !dmem_ack) dmemWait <= dmemWait + 1;
    else                       dmemWait <= 0;
    if (dmem_req && dmem_ack && dmem_we) begin
      wrAddrLog[dmemWrites % 64] <= dmem_addr;
      wrDataLog[dmemWrites % 64] <= dmem_wdata;
      dmemWrites <= dmemWrites + 1;
    end
    if (imem_req === 1'b1 && dmem_req === 1'b1) overlaps <= overlaps + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearProg();
    for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic runUntilHalt(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (halted === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    clearProg();
    imem[0] = 16'h0000;
    rst = 1'b1;
    tick();
    assertions++;
    if (imem_req !== 1'b1) begin failures++; $display("[TB] FAIL reset_imem_req got %b expected 1", imem_req); end
    assertions++;
    if (imem_addr !== 8'h00) begin failures++; $display("[TB] FAIL reset_imem_addr got %h expected 00", imem_addr); end
    assertions++;
    if (dmem_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_dmem_req got %b expected 0", dmem_req); end
    assertions++;
    if (halted !== 1'b0) begin failures++; $display("[TB] FAIL reset_halted got %b expected 0", halted); end
    tick();
    assertions++;
    if (dbg_pc !== 8'h00) begin failures++; $display("[TB] FAIL reset_pc_hold got %h expected 00", dbg_pc); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int w0;
    bit ok;
    imemDelay = 0; dmemDelay = 0;
    clearProg();
    imem[0] = 16'h8105; imem[1] = 16'h8205; imem[2] = 16'h2312; imem[3] = 16'hC006;
    imem[6] = 16'hA003; imem[7] = 16'hF000;
    w0 = dmemWrites;
    doReset();
    repeat (7) tick();
    assertions++;
    if (dbg_pc !== 8'h03) begin failures++; $display("[TB] FAIL basic_pc_before_jz got %h expected 03", dbg_pc); end
    tick();
    assertions++;
    if (dbg_pc !== 8'h06) begin failures++; $display("[TB] FAIL basic_jz_taken got %h expected 06", dbg_pc); end
    runUntilHalt(20, ok);
    assertions++;
    if (!ok) begin failures++; $display("[TB] FAIL basic_halt_timeout got running expected halted"); end
    assertions++;
    if (dmemWrites - w0 !== 1) begin failures++; $display("[TB] FAIL basic_write_count got %0d expected 1", dmemWrites - w0); end
    assertions++;
    if (wrDataLog[w0 % 64] !== 8'h00) begin failures++; $display("[TB] FAIL basic_r3_value got %h expected 00", wrDataLog[w0 % 64]); end
    assertions++;
    if (dbg_pc !== 8'h07) begin failures++; $display("[TB] FAIL basic_halt_pc got %h expected 07", dbg_pc); end
  endtask

  task automatic test_wrap();
    int w0;
    bit ok;
    logic [7:0] expAddr [3];
    logic [7:0] expData [3];
    imemDelay = 0; dmemDelay = 0;
    clearProg();
    imem[0]  = 16'h81FF; imem[1]  = 16'h8201; imem[2]  = 16'h1312; imem[3]  = 16'hC005;
    imem[5]  = 16'hA003; imem[6]  = 16'h8480; imem[7]  = 16'h4644; imem[8]  = 16'h6540;
    imem[9]  = 16'hC00B; imem[11] = 16'hA015; imem[12] = 16'hA026;
    expAddr[0] = 8'h00; expData[0] = 8'h00;
    expAddr[1] = 8'hFF; expData[1] = 8'h00;
    expAddr[2] = 8'h01; expData[2] = 8'h80;
    w0 = dmemWrites;
    doReset();
    runUntilHalt(60, ok);
    assertions++;
    if (dbg_pc !== 8'h0D) begin failures++; $display("[TB] FAIL wrap_halt_pc got %h expected 0d", dbg_pc); end
    assertions++;
    if (dmemWrites - w0 !== 3) begin failures++; $display("[TB] FAIL wrap_write_count got %0d expected 3", dmemWrites - w0); end
    for (int k = 0; k < 3; k++) begin
      assertions++;
      if (wrAddrLog[(w0 + k) % 64] !== expAddr[k] || wrDataLog[(w0 + k) % 64] !== expData[k]) begin
        failures++;
        $display("[TB] FAIL wrap_store%0d got %h:%h expected %h:%h", k,
                 wrAddrLog[(w0 + k) % 64], wrDataLog[(w0 + k) % 64], expAddr[k], expData[k]);
      end
    end
  endtask

  task automatic test_alu();
    int w0;
    bit ok;
    logic [7:0] expData [4];
    imemDelay = 0; dmemDelay = 0;
    clearProg();
    imem[0]  = 16'h81C5; imem[1]  = 16'h823C; imem[2]  = 16'h3312; imem[3]  = 16'h4412;
    imem[4]  = 16'h5512; imem[5]  = 16'h7610; imem[6]  = 16'hD009;
    imem[9]  = 16'h8710; imem[10] = 16'h8811; imem[11] = 16'h8912; imem[12] = 16'h8A13;
    imem[13] = 16'hA073; imem[14] = 16'hA084; imem[15] = 16'hA095; imem[16] = 16'hA0A6;
    imem[17] = 16'hB014;
    expData[0] = 8'h04; expData[1] = 8'hFD; expData[2] = 8'hF9; expData[3] = 8'h62;
    w0 = dmemWrites;
    doReset();
    runUntilHalt(80, ok);
    assertions++;
    if (dbg_pc !== 8'h14) begin failures++; $display("[TB] FAIL alu_halt_pc got %h expected 14", dbg_pc); end
    for (int k = 0; k < 4; k++) begin
      assertions++;
      if (wrAddrLog[(w0 + k) % 64] !== 8'(8'h10 + k) || wrDataLog[(w0 + k) % 64] !== expData[k]) begin
        failures++;
        $display("[TB] FAIL alu_result%0d got %h:%h expected %h:%h", k,
                 wrAddrLog[(w0 + k) % 64], wrDataLog[(w0 + k) % 64], 8'(8'h10 + k), expData[k]);
      end
    end
  endtask

  task automatic test_st_wait();
    int w0;
    int cnt;
    bit stable;
    imemDelay = 0; dmemDelay = 3;
    clearProg();
    imem[0] = 16'h815A; imem[1] = 16'h8240; imem[2] = 16'hA021;
    w0 = dmemWrites;
    doReset();
    repeat (6) tick();
    cnt = 0;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (dmem_req !== 1'b1) break;
      cnt++;
      if (dmem_addr !== 8'h40 || dmem_wdata !== 8'h5A || dmem_we !== 1'b1 || dbg_pc !== 8'h02) stable = 1'b0;
      tick();
    end
    assertions++;
    if (cnt !== 4) begin failures++; $display("[TB] FAIL st_req_cycles got %0d expected 4", cnt); end
    assertions++;
    if (!stable) begin failures++; $display("[TB] FAIL st_req_stable got unstable expected stable"); end
    assertions++;
    if (dmemWrites - w0 !== 1) begin failures++; $display("[TB] FAIL st_write_count got %0d expected 1", dmemWrites - w0); end
    assertions++;
    if (wrAddrLog[w0 % 64] !== 8'h40 || wrDataLog[w0 % 64] !== 8'h5A) begin
      failures++;
      $display("[TB] FAIL st_write_value got %h:%h expected 40:5a", wrAddrLog[w0 % 64], wrDataLog[w0 % 64]);
    end
    assertions++;
    if (dbg_pc !== 8'h03) begin failures++; $display("[TB] FAIL st_pc_advance got %h expected 03", dbg_pc); end
  endtask

  task automatic test_ld_wait();
    int w0;
    int ov0;
    int n;
    bit ok;
    imemDelay = 2; dmemDelay = 1;
    clearProg();
    imem[0] = 16'h8230; imem[1] = 16'h9520; imem[2] = 16'hA005;
    w0  = dmemWrites;
    ov0 = overlaps;
    doReset();
    for (int i = 0; i < 20; i++) begin
      if (dbg_pc === 8'h01) break;
      tick();
    end
    n = 0;
    while (dbg_pc !== 8'h02 && n < 20) begin
      tick();
      n++;
    end
    assertions++;
    if (n !== 6) begin failures++; $display("[TB] FAIL ld_latency got %0d expected 6", n); end
    runUntilHalt(40, ok);
    assertions++;
    if (!ok) begin failures++; $display("[TB] FAIL ld_halt_timeout got running expected halted"); end
    assertions++;
    if (dmemWrites - w0 !== 1 || wrDataLog[w0 % 64] !== 8'h95) begin
      failures++;
      $display("[TB] FAIL ld_value got %0d writes data %h expected 1 writes data 95", dmemWrites - w0, wrDataLog[w0 % 64]);
    end
    assertions++;
    if (overlaps - ov0 !== 0) begin failures++; $display("[TB] FAIL ld_overlap got %0d expected 0", overlaps - ov0); end
    imemDelay = 0; dmemDelay = 0;
  endtask

  task automatic test_jal_halt();
    int w0;
    int reqs;
    bit ok;
    imemDelay = 0; dmemDelay = 0;
    clearProg();
    imem[0] = 16'h8420; imem[1] = 16'h0000; imem[2] = 16'h0000; imem[3] = 16'hE440;
    imem[32] = 16'hA004; imem[33] = 16'hF000;
    w0 = dmemWrites;
    doReset();
    repeat (8) tick();
    assertions++;
    if (dbg_pc !== 8'h20) begin failures++; $display("[TB] FAIL jal_target got %h expected 20", dbg_pc); end
    runUntilHalt(20, ok);
    assertions++;
    if (wrDataLog[w0 % 64] !== 8'h04 || dmemWrites - w0 !== 1) begin
      failures++;
      $display("[TB] FAIL jal_link got %h expected 04", wrDataLog[w0 % 64]);
    end
    assertions++;
    if (halted !== 1'b1 || dbg_pc !== 8'h21) begin
      failures++;
      $display("[TB] FAIL hlt_state got halted=%b pc=%h expected halted=1 pc=21", halted, dbg_pc);
    end
    reqs = 0;
    repeat (10) begin
      tick();
      if (imem_req !== 1'b0 || dmem_req !== 1'b0) reqs++;
    end
    assertions++;
    if (reqs !== 0 || halted !== 1'b1) begin
      failures++;
      $display("[TB] FAIL hlt_quiet got %0d request cycles halted=%b expected 0 halted=1", reqs, halted);
    end
    rst = 1'b1;
    tick();
    assertions++;
    if (halted !== 1'b0 || imem_req !== 1'b1) begin
      failures++;
      $display("[TB] FAIL hlt_reset_exit got halted=%b imem_req=%b expected 0 1", halted, imem_req);
    end
    rst = 1'b0;
  endtask

  task automatic test_narrow();
    for (int i = 0; i < 256; i++) imem2[i] = 16'hF000;
    imem2[0] = 16'h85AB; imem2[1] = 16'h8250; imem2[2] = 16'hA021; imem2[3] = 16'h9320;
    ack2En = 1'b1;
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    repeat (6) tick();
    assertions++;
    if (dmem_req2 !== 1'b1 || dmem_we2 !== 1'b1 || dmem_addr2 !== 16'h0050 || dmem_wdata2 !== 16'h00AB) begin
      failures++;
      $display("[TB] FAIL narrow_rd_alias got req=%b we=%b addr=%h data=%h expected 1 1 0050 00ab",
               dmem_req2, dmem_we2, dmem_addr2, dmem_wdata2);
    end
    tick();
    ack2En = 1'b0;
    repeat (3) tick();
    assertions++;
    if (dmem_req2 !== 1'b1 || dmem_we2 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL narrow_ld_pending got req=%b we=%b expected 1 0", dmem_req2, dmem_we2);
    end
    rst2 = 1'b1;
    tick();
    assertions++;
    if (dmem_req2 !== 1'b0 || dbg_pc2 !== 8'h00 || halted2 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL narrow_reset_abort got req=%b pc=%h halted=%b expected 0 00 0", dmem_req2, dbg_pc2, halted2);
    end
    imem2[0] = 16'hA021;
    ack2En = 1'b1;
    rst2 = 1'b0;
    tick();
    tick();
    assertions++;
    if (dmem_req2 !== 1'b1 || dmem_addr2 !== 16'h0000 || dmem_wdata2 !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL narrow_regs_cleared got req=%b addr=%h data=%h expected 1 0000 0000",
               dmem_req2, dmem_addr2, dmem_wdata2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_alu();
    test_st_wait();
    test_ld_wait();
    test_jal_halt();
    test_narrow();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/mc_core.md
MC_CORE -- requirements
Module: mc_core

Interface
REQ-001: Parameter DATA_W, default 8, datapath/register/data-address width (legal 8..32).
REQ-002: Parameter PC_W, default 8, program-counter and instruction-address width (legal 4..DATA_W).
REQ-003: Parameter NREG, default 16, register count (power of two, 2..16).
REQ-004: Port clk  input  1  sole clock, all state on rising edge.
REQ-005: Port rst  input  1  synchronous active-high reset.
REQ-006: Port imem_req  output  1  instruction fetch request.
REQ-007: Port imem_addr  output  PC_W  fetch address (= PC).
REQ-008: Port imem_ack  input  1  fetch complete, imem_data valid this cycle.
REQ-009: Port imem_data  input  16  instruction word.
REQ-010: Port dmem_req  output  1  data access request.
REQ-011: Port dmem_we  output  1  1 = store, 0 = load (valid while dmem_req).
REQ-012: Port dmem_addr  output  DATA_W  data address.
REQ-013: Port dmem_wdata  output  DATA_W  store data.
REQ-014: Port dmem_ack  input  1  access complete; dmem_rdata valid this cycle for loads.
REQ-015: Port dmem_rdata  input  DATA_W  load data.
REQ-016: Port halted  output  1  core in HALT state.
REQ-017: Port dbg_pc  output  PC_W  current PC.

Function
REQ-018: Instruction fields: op=[15:12], rd=[11:8], rs0=[7:4], rs1=[3:0], imm=[7:0]; register index uses low log2(NREG) bits of field.
REQ-019: Opcodes: 0 NOP; 1 ADD rd=rs0+rs1; 2 SUB rd=rs0-rs1; 3 AND; 4 OR; 5 XOR; 6 SHL rd=rs0<<1; 7 SHR rd=rs0>>1 logical; 8 LDI rd=zero-ext imm; 9 LD rd=mem[rs0]; A ST mem[rs0]=rs1; B JMP pc=imm; C JZ pc=imm if Z else pc+1; D JNZ inverse of JZ; E JAL rd=zero-ext(pc+1), pc=rs0[PC_W-1:0]; F HLT.
REQ-020: Arithmetic modulo 2^DATA_W; no carry/overflow flag; jump targets truncated to PC_W bits; PC+1 wraps 2^PC_W-1 -> 0.
REQ-021: Z flag set to (result==0) only by opcodes 1-7; all other opcodes leave Z unchanged.
REQ-022: FSM states FETCH, EXEC, MEM, HALT.
REQ-023: FETCH: imem_req=1, imem_addr=PC; on imem_ack latch imem_data into IR, go EXEC; otherwise hold req and address stable.
REQ-024: EXEC for opcodes 0-8, B-E: write rd (if applicable), update Z, update PC, go FETCH in the same cycle; instruction latency = fetch cycles + 1.
REQ-025: EXEC for 9/A: go MEM; PC unchanged.
REQ-026: MEM: dmem_req=1, dmem_addr=rs0, dmem_we=(op==A), dmem_wdata=rs1, all stable until dmem_ack; on ack LD writes dmem_rdata to rd, PC=PC+1, go FETCH.
REQ-027: EXEC for F: go HALT; PC unchanged; HALT persists until rst; no requests issued.
REQ-028: imem_ack outside FETCH and dmem_ack outside MEM ignored.
REQ-029: Zero-wait memories (ack same cycle as req): ALU/jump instructions take 2 cycles, LD/ST 3 cycles.
REQ-030: JAL with rd==rs0: target read before link write (old rs0 value used).
REQ-031: imem_req and dmem_req never asserted in the same cycle.

Reset
REQ-032: On rst at a clock edge: state=FETCH, PC=0, Z=0, IR=0, all registers 0; takes priority over any ack in that cycle.
REQ-033: In the cycle after the reset edge (rst still high): imem_req=1 with imem_addr=0 allowed, dmem_req=0, halted=0, dbg_pc=0.
REQ-034: rst during MEM or pending fetch abandons the access; no register write, dmem_req low after the edge.

Verification
REQ-035: Reset, zero-wait memories, program LDI r1,5; LDI r2,5; SUB r3,r1,r2; JZ 6 -> r3=0, Z=1, dbg_pc reaches 6.
REQ-036: DATA_W=8: LDI r1,0xFF; LDI r2,1; ADD r3,r1,r2 -> r3=0x00, Z=1; SHL of 0x80 -> 0x00, Z=1.
REQ-037: dmem_ack delayed 3 cycles on ST r1->[r2] -> dmem_req/addr/wdata/we constant for 4 cycles, single write, PC advances once.
REQ-038: LD with imem_ack delayed 2 cycles and dmem_ack delayed 1 -> correct rd, total 6 cycles, no overlapping requests.
REQ-039: JAL r4,r4 with r4=0x20 at PC=3 -> PC=0x20, r4=4; HLT -> halted=1, no further requests until rst.
REQ-040: DATA_W=16, NREG=4: rd field 5 writes r1; rst asserted while dmem_req pending -> PC=0, regs 0, dmem_req low.
